mul_pipe_stage: RTL and testbench

MUL_PIPE_STAGE -- requirements
Module: mul_pipe_stage

---
 rtl/mul_pipe_stage.sv | 115 +++++++++++
 tb/tb_mul_pipe_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mul_pipe_stage.sv
// Two-stage multiply pipeline with valid/ready handshake. Stage 1 takes operand
// magnitudes and the result sign. Stage 2 restores the sign and selects the half.

module mul_array #(
    parameter int L = 16
) (
    input  logic [L-1:0] x,
    input  logic [L-1:0] y,
    output logic [L-1:0] lo,
    output logic [L-1:0] hi
);
    // Row i holds the running sum of partial products 0..i.
    logic [L-1:0][2*L-1:0] acc;

    assign acc[0] = y[0] ? {{L{1'b0}}, x} : '0;

    for (genvar i = 1; i < L; i++) begin : g_row
        assign acc[i] = acc[i-1] + (y[i] ? ({{L{1'b0}}, x} << i) : '0);
    end

    assign {hi, lo} = acc[L-1];
endmodule

module mul_pipe_stage #(
    parameter int L = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [L-1:0] a,
    input  logic [L-1:0] b,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [L-1:0] result,
    output logic         busy
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    logic         s1_valid, s2_valid, s1_neg;
    logic [1:0]   s1_op;
    logic [L-1:0] s1_a, s1_b;

    logic         s2_load, accept;
    logic         a_neg, b_neg;
    logic [L-1:0] a_mag, b_mag;
    logic [L-1:0] r1, r2;
    logic [2*L-1:0] prod, prod_signed;
    logic [L-1:0] res_next;

    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = rst_n && !flush && (!s1_valid || s2_load);
    assign accept   = in_valid && in_ready;

    // The most-negative value negates to itself, which read unsigned is its magnitude.
    always_comb begin
        a_neg = a[L-1] && ((op == OP_MULH) || (op == OP_MULHSU));
        b_neg = b[L-1] && (op == OP_MULH);
        a_mag = a_neg ? (~a + L'(1)) : a;
        b_mag = b_neg ? (~b + L'(1)) : b;
    end

    mul_array #(.L(L)) u_core (
        .x  (s1_a),
        .y  (s1_b),
        .lo (r1),
        .hi (r2)
    );

    always_comb begin
        prod        = {r2, r1};
        prod_signed = s1_neg ? (~prod + (2*L)'(1)) : prod;
        res_next    = (s1_op == OP_MUL) ? prod_signed[L-1:0] : prod_signed[2*L-1:L];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_neg   <= 1'b0;
            s1_op    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a_mag;
            s1_b     <= b_mag;
            s1_neg   <= a_neg ^ b_neg;
            s1_op    <= op;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // The result register only changes when a real operation moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) result <= res_next;
        end
    end

    assign out_valid = s2_valid;
    assign busy      = s1_valid || s2_valid;
endmodule

// File: tb/tb_mul_pipe_stage.sv
// Scoreboard bench for mul_pipe_stage: the driver queues hand-computed results
// on accept and an independent monitor pops them whenever an output transfers.

module tb_mul_pipe_stage;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [1:0]  op;
    logic [15:0] a, b, result;

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] sb[$];

    logic        prev_stall = 1'b0;
    logic        prev_flush = 1'b0;
    logic [15:0] prev_res   = '0;

    mul_pipe_stage #(.L(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pop on every output transfer and check hold during backpressure.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n && prev_stall && !prev_flush) begin
            chk("hold_valid", {31'b0, out_valid}, 32'd1);
            chk("hold_result", {16'b0, result}, {16'b0, prev_res});
        end
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_out: got result %h, expected no output at %0t", result, $time);
            end else begin
                e = sb.pop_front();
                chk("result", {16'b0, result}, {16'b0, e});
            end
        end
        prev_stall = rst_n && out_valid && !out_ready;
        prev_flush = flush;
        prev_res   = result;
    end

    // Called at posedge+#1; returns at accept edge+#1 with in_valid still high.
    task automatic send(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] e);
        op = o; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: got in_ready 0 for 20 cycles, expected accept");
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) done = 1'b1;
        end
        chk("drain", {31'b0, done}, 32'd1);
        @(posedge clk); #1;
    endtask

    logic [1:0]  t_op[12];
    logic [15:0] t_a[12], t_b[12], t_r[12];

    initial begin
        t_op = '{2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
        t_a  = '{16'h0003, 16'hFFFF, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h1234,
                 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h0000, 16'hFFFF};
        t_b  = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0002, 16'h0010,
                 16'h0001, 16'h7FFF, 16'hFFFF, 16'h0002, 16'h8000, 16'hFFFF};
        t_r  = '{16'h000F, 16'hFFFE, 16'h0000, 16'h4000, 16'hFFFF, 16'h2340,
                 16'hFFFF, 16'h3FFF, 16'h8000, 16'h0001, 16'h0000, 16'h0001};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", {16'b0, result}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency: s1 after accept edge, out_valid after the following edge.
        send(2'b00, 16'h0003, 16'h0005, 16'h000F);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_early", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_2cyc", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        drain();

        // Back-to-back directed stream, one op per cycle.
        for (int i = 0; i < 12; i++) send(t_op[i], t_a[i], t_b[i], t_r[i]);
        in_valid = 1'b0;
        drain();

        // Four-op stream with a 3-cycle stall after two accepts.
        send(2'b11, 16'h0100, 16'h0100, 16'h0001);
        send(2'b00, 16'h0007, 16'h0009, 16'h003F);
        out_ready = 1'b0;
        op = 2'b01; a = 16'hFFFE; b = 16'h0003; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
            chk("stall_busy", {31'b0, busy}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(2'b01, 16'hFFFE, 16'h0003, 16'hFFFF);
        send(2'b10, 16'h8000, 16'h0002, 16'hFFFF);
        in_valid = 1'b0;
        drain();

        // Reset with two ops in flight.
        out_ready = 1'b0;
        send(2'b00, 16'h0011, 16'h0011, 16'h0121);
        send(2'b00, 16'h0022, 16'h0002, 16'h0044);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_result", {16'b0, result}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
        sb.delete();
        out_ready = 1'b1;
        @(posedge clk); #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;

        // Flush with both stages full and a new op offered.
        out_ready = 1'b0;
        send(2'b11, 16'h0003, 16'h0003, 16'h0000);
        send(2'b11, 16'h0004, 16'h0004, 16'h0000);
        op = 2'b00; a = 16'h0002; b = 16'h0002; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush_no_accept", {31'b0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
